// File: rtl/abejaruco_pkg.sv
// Shared memory-side types and default widths.
// Used by the caches and the memory-port arbiter.
package abejaruco_pkg;

   localparam int ADDR_W_DEF       = 32;
   localparam int LINE_W_DEF       = 128;
   localparam int STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   typedef enum logic {
      OWNER_IC = 1'b0,
      OWNER_DC = 1'b1
   } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of data grants taken while an ifetch waits.
// at_limit flips arbitration to the icache side.
module starve_counter
   import abejaruco_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   assign at_limit = (cnt == W'(LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !at_limit) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the main-memory port between icache refill and dcache traffic.
// Data side wins unless ifetch has been starved STARVE_LIMIT times.
module mem_port_arbiter
   import abejaruco_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int LINE_W       = LINE_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_done,
   output logic [LINE_W-1:0] ic_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_done,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy
);

   state_t state;
   owner_t owner;
   logic   at_limit;
   logic   arb;
   logic   grant_dc;
   logic   grant_ic;

   assign arb      = (state == ST_IDLE);
   assign grant_dc = dc_req && !(ic_req && at_limit);
   assign grant_ic = ic_req && !grant_dc;
   assign busy     = (state != ST_IDLE);

   starve_counter #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (arb && grant_dc && ic_req),
      .clr     (arb && grant_ic),
      .at_limit(at_limit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         owner     <= OWNER_IC;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ic_done   <= 1'b0;
         dc_done   <= 1'b0;
         ic_rdata  <= '0;
         dc_rdata  <= '0;
      end else begin
         mem_req <= 1'b0;
         ic_done <= 1'b0;
         dc_done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               unique case (1'b1)
                  grant_dc: begin
                     owner     <= OWNER_DC;
                     mem_we    <= dc_we;
                     mem_addr  <= dc_addr;
                     mem_wdata <= dc_wdata;
                     mem_req   <= 1'b1;
                     state     <= ST_LAUNCH;
                  end
                  grant_ic: begin
                     owner     <= OWNER_IC;
                     mem_we    <= 1'b0;
                     mem_addr  <= ic_addr;
                     mem_wdata <= '0;
                     mem_req   <= 1'b1;
                     state     <= ST_LAUNCH;
                  end
                  default: ;
               endcase
            end
            ST_LAUNCH: state <= ST_WAIT;
            ST_WAIT: begin
               if (mem_ready) begin
                  // writebacks leave dc_rdata holding the last refill
                  if (owner == OWNER_IC) begin
                     ic_rdata <= mem_rdata;
                  end else if (!mem_we) begin
                     dc_rdata <= mem_rdata;
                  end
                  ic_done <= (owner == OWNER_IC);
                  dc_done <= (owner == OWNER_DC);
                  state   <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a variable-latency memory.
// Stimulus changes and sampling happen on the falling edge.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ic_req = 1'b0;
   logic [AW-1:0] ic_addr = '0;
   logic          ic_done;
   logic [LW-1:0] ic_rdata;
   logic          dc_req = 1'b0;
   logic          dc_we = 1'b0;
   logic [AW-1:0] dc_addr = '0;
   logic [LW-1:0] dc_wdata = '0;
   logic          dc_done;
   logic [LW-1:0] dc_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic          mem_ready;
   logic [LW-1:0] mem_rdata;
   logic          busy;

   int            n_checks = 0;
   int            n_pass = 0;
   int            lat = 1;
   logic [LW-1:0] mem_data = '0;
   logic [AW-1:0] grant_log[$];
   int            both_pulses = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ic_req   (ic_req),
      .ic_addr  (ic_addr),
      .ic_done  (ic_done),
      .ic_rdata (ic_rdata),
      .dc_req   (dc_req),
      .dc_we    (dc_we),
      .dc_addr  (dc_addr),
      .dc_wdata (dc_wdata),
      .dc_done  (dc_done),
      .dc_rdata (dc_rdata),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .busy     (busy)
   );

   // memory model: ready lands lat cycles after the launch cycle
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req === 1'b1) begin
            grant_log.push_back(mem_addr);
            repeat (lat) @(negedge clk);
            mem_ready = 1'b1;
            mem_rdata = mem_data;
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = '0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (ic_done === 1'b1 && dc_done === 1'b1) both_pulses++;
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({ic_done, dc_done, mem_req, mem_we, busy} !== 5'b0)
         $display("FAIL rst_ctrl: got %b want 00000",
                  {ic_done, dc_done, mem_req, mem_we, busy});
      else n_pass++;
      n_checks++;
      if (mem_addr !== '0)
         $display("FAIL rst_addr: got %h want 0", mem_addr);
      else n_pass++;
      n_checks++;
      if (mem_wdata !== '0)
         $display("FAIL rst_wdata: got %h want 0", mem_wdata);
      else n_pass++;
      n_checks++;
      if (ic_rdata !== '0 || dc_rdata !== '0)
         $display("FAIL rst_rdata: got %h/%h want 0", ic_rdata, dc_rdata);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ic_read();
      logic [LW-1:0] exp_line;
      exp_line = {4{32'hDEADBEEF}};
      lat      = 3;
      mem_data = exp_line;
      ic_addr  = 32'h40;
      ic_req   = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (mem_req !== (k == 1))
            $display("FAIL ic_mem_req c%0d: got %b want %b", k, mem_req, k == 1);
         else n_pass++;
         n_checks++;
         if (ic_done !== (k == 5))
            $display("FAIL ic_done c%0d: got %b want %b", k, ic_done, k == 5);
         else n_pass++;
         n_checks++;
         if (dc_done !== 1'b0)
            $display("FAIL ic_dc_done c%0d: got %b want 0", k, dc_done);
         else n_pass++;
         n_checks++;
         if (busy !== (k <= 5))
            $display("FAIL ic_busy c%0d: got %b want %b", k, busy, k <= 5);
         else n_pass++;
         if (k == 1) begin
            n_checks++;
            if (mem_addr !== 32'h40 || mem_we !== 1'b0)
               $display("FAIL ic_launch: got %h/%b want 40/0", mem_addr, mem_we);
            else n_pass++;
         end
         if (k == 5) begin
            n_checks++;
            if (ic_rdata !== exp_line)
               $display("FAIL ic_rdata: got %h want %h", ic_rdata, exp_line);
            else n_pass++;
            ic_req = 1'b0;
         end
      end
   endtask

   task automatic test_dc_write();
      logic [LW-1:0] wline;
      wline    = {16{8'hA5}};
      lat      = 1;
      mem_data = {4{32'h12345678}};
      dc_addr  = 32'h100;
      dc_wdata = wline;
      dc_we    = 1'b1;
      dc_req   = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (mem_req !== (k == 1))
            $display("FAIL dw_mem_req c%0d: got %b want %b", k, mem_req, k == 1);
         else n_pass++;
         n_checks++;
         if (dc_done !== (k == 3) || ic_done !== 1'b0)
            $display("FAIL dw_done c%0d: got %b/%b want %b/0",
                     k, dc_done, ic_done, k == 3);
         else n_pass++;
         if (k <= 2) begin
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== wline)
               $display("FAIL dw_hold c%0d: got %b/%h/%h want 1/100/%h",
                        k, mem_we, mem_addr, mem_wdata, wline);
            else n_pass++;
         end
         if (k == 3) begin
            n_checks++;
            if (dc_rdata !== '0)
               $display("FAIL dw_rdata: got %h want 0", dc_rdata);
            else n_pass++;
            dc_req = 1'b0;
            dc_we  = 1'b0;
         end
      end
   endtask

   task automatic test_starvation();
      int base;
      int n_ic;
      int n_dc;
      int cyc;
      logic [AW-1:0] exp_a;
      base     = grant_log.size();
      n_ic     = 0;
      n_dc     = 0;
      cyc      = 0;
      lat      = 1;
      mem_data = {4{32'h0F0F0F0F}};
      ic_addr  = 32'h1000;
      dc_addr  = 32'h2000;
      dc_we    = 1'b0;
      ic_req   = 1'b1;
      dc_req   = 1'b1;
      while (n_ic + n_dc < 10 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (ic_done === 1'b1) n_ic++;
         if (dc_done === 1'b1) n_dc++;
      end
      ic_req = 1'b0;
      dc_req = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (n_ic + n_dc != 10)
         $display("FAIL st_timeout: got %0d dones want 10", n_ic + n_dc);
      else n_pass++;
      n_checks++;
      if (n_ic != 2)
         $display("FAIL st_ic_dones: got %0d want 2", n_ic);
      else n_pass++;
      n_checks++;
      if (grant_log.size() - base != 10)
         $display("FAIL st_grants: got %0d want 10", grant_log.size() - base);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         exp_a = (i == 4 || i == 9) ? 32'h1000 : 32'h2000;
         n_checks++;
         if (base + i >= grant_log.size())
            $display("FAIL st_order%0d: got none want %h", i, exp_a);
         else if (grant_log[base+i] !== exp_a)
            $display("FAIL st_order%0d: got %h want %h", i, grant_log[base+i], exp_a);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int n_done;
      int n_req;
      logic [LW-1:0] exp_line;
      lat      = 6;
      mem_data = {4{32'hBAD0BAD0}};
      ic_addr  = 32'h40;
      ic_req   = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1)
         $display("FAIL rm_busy_pre: got %b want 1", busy);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ic_done, dc_done, mem_req, mem_we, busy} !== 5'b0 ||
          mem_addr !== '0 || mem_wdata !== '0)
         $display("FAIL rm_async: got %b/%h want 00000/0",
                  {ic_done, dc_done, mem_req, mem_we, busy}, mem_addr);
      else n_pass++;
      n_checks++;
      if (ic_rdata !== '0 || dc_rdata !== '0)
         $display("FAIL rm_rdata: got %h/%h want 0", ic_rdata, dc_rdata);
      else n_pass++;
      ic_req = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      n_req  = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ic_done === 1'b1 || dc_done === 1'b1) n_done++;
         if (mem_req === 1'b1 || busy === 1'b1) n_req++;
      end
      n_checks++;
      if (n_done != 0 || n_req != 0)
         $display("FAIL rm_late_ready: got done %0d act %0d want 0", n_done, n_req);
      else n_pass++;
      n_checks++;
      if (ic_rdata !== '0)
         $display("FAIL rm_late_data: got %h want 0", ic_rdata);
      else n_pass++;
      exp_line = {4{32'hCAFEF00D}};
      lat      = 2;
      mem_data = exp_line;
      dc_addr  = 32'h300;
      dc_we    = 1'b0;
      dc_req   = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_we !== 1'b0)
               $display("FAIL rm_relaunch: got %b/%h/%b want 1/300/0",
                        mem_req, mem_addr, mem_we);
            else n_pass++;
         end
         n_checks++;
         if (dc_done !== (k == 4))
            $display("FAIL rm_dc_done c%0d: got %b want %b", k, dc_done, k == 4);
         else n_pass++;
         if (k == 4) begin
            n_checks++;
            if (dc_rdata !== exp_line)
               $display("FAIL rm_dc_rdata: got %h want %h", dc_rdata, exp_line);
            else n_pass++;
            dc_req = 1'b0;
         end
      end
   endtask

   task automatic test_hold_resp();
      int base;
      int n_req;
      int n_done;
      base     = grant_log.size();
      n_req    = 0;
      n_done   = 0;
      lat      = 1;
      mem_data = {4{32'h0BADCAFE}};
      dc_addr  = 32'h400;
      dc_we    = 1'b0;
      dc_req   = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_req === 1'b1) n_req++;
         if (dc_done === 1'b1) begin
            n_done++;
            dc_req = 1'b0;
         end
      end
      n_checks++;
      if (n_req != 1)
         $display("FAIL hr_mem_req: got %0d want 1", n_req);
      else n_pass++;
      n_checks++;
      if (n_done != 1)
         $display("FAIL hr_done: got %0d want 1", n_done);
      else n_pass++;
      n_checks++;
      if (grant_log.size() - base != 1)
         $display("FAIL hr_grants: got %0d want 1", grant_log.size() - base);
      else n_pass++;
   endtask

   task automatic test_addr_stable();
      logic [LW-1:0] exp_line;
      exp_line = {4{32'h5555AAAA}};
      lat      = 4;
      mem_data = exp_line;
      ic_addr  = 32'h40;
      ic_req   = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k <= 5) begin
            n_checks++;
            if (mem_addr !== 32'h40)
               $display("FAIL as_addr c%0d: got %h want 40", k, mem_addr);
            else n_pass++;
         end
         if (k == 2) ic_addr = 32'h80;
         n_checks++;
         if (ic_done !== (k == 6))
            $display("FAIL as_done c%0d: got %b want %b", k, ic_done, k == 6);
         else n_pass++;
         if (k == 6) begin
            n_checks++;
            if (ic_rdata !== exp_line)
               $display("FAIL as_rdata: got %h want %h", ic_rdata, exp_line);
            else n_pass++;
            ic_req = 1'b0;
         end
      end
      n_checks++;
      if (busy !== 1'b0)
         $display("FAIL as_idle: got %b want 0", busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ic_read();
      test_dc_write();
      test_starvation();
      test_reset_mid();
      test_hold_resp();
      test_addr_stable();
      n_checks++;
      if (both_pulses != 0)
         $display("FAIL both_done: got %0d want 0", both_pulses);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Sits between both cache controllers and the memory model.
- Its one-cycle done pulses feed the caches, and from them the stall unit's icache_op_done and data-side stall logic.
- Fixed data-side priority, with a starvation counter that guarantees forward progress for instruction fetch.

Parameters:
ADDR_W, 32, byte-address width
LINE_W, 128, cache-line width in bits (one memory transaction = one line)
STARVE_LIMIT, 4, consecutive data grants tolerated while ic_req waits; 1..15

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
ic_req  in  1  icache line-read request, level, held until ic_done
ic_addr  in  ADDR_W  icache line address, stable while ic_req
ic_done  out  1  one-cycle pulse, ic_rdata valid
ic_rdata  out  LINE_W  registered line for icache
dc_req  in  1  dcache request, level, held until dc_done
dc_we  in  1  1 = writeback line, 0 = refill read
dc_addr  in  ADDR_W  dcache line address
dc_wdata  in  LINE_W  writeback line
dc_done  out  1  one-cycle pulse, dc_rdata valid (reads)
dc_rdata  out  LINE_W  registered line for dcache
mem_req  out  1  one-cycle launch pulse to memory
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  ADDR_W  held from launch until completion
mem_wdata  out  LINE_W  held from launch until completion
mem_ready  in  1  one-cycle completion pulse from memory, variable latency >= 1
mem_rdata  in  LINE_W  valid while mem_ready
busy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all outputs 0 (ic_done, dc_done, mem_req, mem_we, busy, mem_addr, mem_wdata, ic_rdata, dc_rdata); starve_cnt = 0.
- Reset mid-transaction abandons it; no done pulse is issued.
- States: IDLE, LAUNCH, WAIT, RESP; owner register (ICACHE/DCACHE).
- IDLE, arbitration:
  - dc_req only → owner DCACHE.
  - ic_req only → owner ICACHE.
  - Both → DCACHE, unless starve_cnt == STARVE_LIMIT, then ICACHE.
  - Winner's addr/we/wdata are latched (icache: we = 0, wdata = 0); next state LAUNCH.
  - No request → stay in IDLE.
  - mem_ready in IDLE is ignored.
- LAUNCH: mem_req = 1 for exactly this cycle, with the latched mem_we/addr/wdata; go to WAIT.
- WAIT: mem_addr/mem_wdata/mem_we held. On mem_ready, capture mem_rdata into the owner's rdata register (dc writes: dc_rdata unchanged); go to RESP.
- RESP: owner's done = 1 for exactly this cycle; go to IDLE.
  - Requesters drop req on the cycle after done. Req is not sampled in RESP, so there is no double grant.
- Latency: grant in IDLE cycle N, mem_req in N+1; mem_ready at N+1+L (L >= 1); done at N+2+L.
- Minimum spacing between consecutive transactions is 4 cycles.
- starve_cnt, updated at the arbitration decision:
  - +1 (saturating at STARVE_LIMIT) when DCACHE wins while ic_req = 1.
  - Reset to 0 when ICACHE wins.
  - Unchanged when ic_req = 0.
- busy = 1 in LAUNCH/WAIT/RESP.
- Only the owner's done ever pulses. ic_done and dc_done are never asserted together.
- Request inputs changing during LAUNCH/WAIT have no effect; latched values are used.

Decomposition:
- Shared package (abejaruco_pkg):
  - State encoding localparams ST_IDLE=2'd0, ST_LAUNCH=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3.
  - OWNER_IC=1'b0, OWNER_DC=1'b1.
  - Default LINE_W/ADDR_W constants shared with the caches.
- One natural sub-module, starve_counter: saturating counter with inc/clr/at_limit, width $clog2(STARVE_LIMIT+1).
- FSM and datapath latches stay in the top.

Test Plan:
- Reset, then ic_req=1, ic_addr=0x0000_0040; memory returns 0xDEADBEEF_... after L=3 → mem_req pulse cycle 1 with mem_addr=0x40, mem_we=0; ic_done exactly cycle 5 with ic_rdata matching; dc_done stays 0.
- dc_req=1, dc_we=1, dc_addr=0x100, dc_wdata=0xA5..A5, L=1 → mem_we=1, mem_wdata held through WAIT, dc_done one pulse; dc_rdata unchanged.
- ic_req and dc_req asserted together and continuously re-requested (STARVE_LIMIT=4) → grant order D,D,D,D,I,D,D,D,D,I; ic_done after at most 5 transactions.
- rst_n pulled low while in WAIT → all outputs 0 asynchronously; a late mem_ready after release is ignored; no done pulse; next request arbitrates normally.
- Requester holds req high through RESP for one cycle → exactly one grant per done; no spurious second mem_req.
- ic_addr changed from 0x40 to 0x80 during WAIT → mem_addr stays 0x40 until completion.
